pkt_sram_responder: RTL and testbench
=====================================

Name: pkt_sram_responder

Overview:
- Packet buffer that sits on the memory side of the 32-bit SRAM bus.
- Responds to one bus initiator (checksum engine, header editors) with one-cycle read latency and byte-enabled writes.
- Fills the same storage from an ingress byte stream, then presents the packet length for downstream engines.

Parameters:
DEPTH_WORDS, 512, number of 32-bit words of storage; must be a power of two.
AW, 9, log2(DEPTH_WORDS); word-index width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sram_ce_i  in  1  bus access enable
sram_we_i  in  1  1 = write, 0 = read
sram_addr_i  in  32  byte address; bits [1:0] ignored, word index = [AW+1:2], upper bits alias
sram_sel_i  in  4  byte enables; bit 3 = lane [31:24]
sram_data_i  in  32  write data
sram_data_o  out  32  read data
in_valid_i  in  1  ingress byte valid
in_ready_o  out  1  ingress byte accepted when valid&ready
in_data_i  in  8  ingress byte
in_last_i  in  1  final byte of packet
pkt_ready_o  out  1  packet stored, buffer held
pkt_len_o  out  32  packet length in bytes
pkt_err_o  out  1  overflow occurred
pkt_release_i  in  1  consumer done; rearm ingress
pkt_cksum_o  out  16  see Optional Feature

Behaviour:
- Reset (sync, active-high): sram_data_o=0, pkt_ready_o=0, pkt_len_o=0, pkt_err_o=0, pkt_cksum_o=0, byte count=0, pending flag=0, state=FILL. in_ready_o=0 while rst=1. Reset mid-packet discards the partial packet; memory contents are not cleared.
- Byte order is big-endian within a word. Packet byte n goes to word n>>2, lane 3-(n%4) (offset 0 -> [31:24]). This matches initiators that take the lower-address halfword from [31:16].
- Read: sram_ce_i=1 and sram_we_i=0 at edge k -> sram_data_o = mem[word] at edge k+1, all four lanes regardless of sel. sram_data_o holds its value when there is no read.
- Bus write: sram_ce_i=1 and sram_we_i=1 writes only the lanes enabled by sel. Accepted in every state.
- Packing: accepted bytes are assembled into a word register plus lane mask.
  - On the 4th byte, or on in_last_i, the word is moved to a pending write (pend_valid=1).
  - Pending write commits on the first cycle with no bus write, using its lane mask. Unfilled lanes of the last word are untouched.
  - Bus write wins a same-cycle conflict; the pending write defers one cycle.
- in_ready_o = (state==FILL) & !pend_valid & !rst, combinational.
- States:
  - FILL: accept bytes. On in_last_i accept -> FLUSH.
  - FLUSH: wait for pend_valid=0. Then pkt_len_o=byte count, pkt_ready_o=1 -> HOLD.
  - HOLD: in_ready_o=0. On pkt_release_i -> pkt_ready_o=0, pkt_err_o=0, count=0 -> FILL on the next cycle.
- pkt_ready_o rises only after the final word is committed. A read issued in the same cycle pkt_ready_o is seen returns the final data.
- Overflow: a byte accepted when count == 4*DEPTH_WORDS is discarded (ready stays high), pkt_err_o=1, and count saturates. in_last_i still ends the packet normally.
- Zero-length packets are impossible, since in_last_i always comes with a byte.
- pkt_release_i outside HOLD is ignored.
- in_valid_i may drop mid-packet without effect.

Optional Feature:
- Macro RESP_CKSUM_EN.
- Defined:
  - Accumulate a 32-bit ones'-complement sum of big-endian halfwords as words are committed to pending. A trailing odd byte is padded with 0x00 in the low byte.
  - In FLUSH, fold twice and invert, then present on pkt_cksum_o together with pkt_ready_o. This is the same fold/invert an initiator-side checksum over [0,len) produces.
  - Cleared on release.
  - Adds no latency to pkt_ready_o beyond the fold cycles; FLUSH lasts at least 2 cycles.
- Undefined: pkt_cksum_o tied to 16'h0000 and no accumulator is synthesised.

Decomposition:
- Shared def.v gains state codes RSP_FILL/RSP_FLUSH/RSP_HOLD and PKT_LEN_MAX; it already holds ADDR_BUS/DATA_BUS/TRUE/FALSE/ZERO_WORD.
- One sub-module, be_word_ram: DEPTH_WORDS x 32 single-port RAM with per-byte write enables and a registered read. It holds the arbitration-free storage; the parent muxes the write source.

Test Plan:
- Ingress 0x45,0x00,0x00,0x1C with last on the 4th byte -> pkt_ready_o=1, pkt_len_o=4. A read at addr 0 returns 0x4500001C one cycle after ce.
- 6-byte packet 01..06 into a word 1 preloaded with 0xAAAAAAAA -> word 1 reads 0x0506AAAA, pkt_len_o=6.
- Bus write at addr 4, sel=1111, on the exact cycle a pending word to word 1 exists -> bus data written first, then the pending data overwrites the lanes it enables. in_ready_o is low that cycle.
- DEPTH_WORDS=4 with a 20-byte packet -> bytes 17..20 discarded, pkt_len_o=16, pkt_err_o=1. Release clears pkt_err_o and the next packet starts at addr 0.
- With RESP_CKSUM_EN, IPv4 header 4500 0073 0000 4000 4011 0000 C0A8 0001 C0A8 00C7 -> pkt_cksum_o=16'hB861.
- rst asserted mid-packet after 3 bytes -> next cycle in_ready_o=0, pkt_ready_o=0. After release of rst a new packet writes from word 0.

Source files
------------

// File: rtl/pkt_sram_responder_pkg.sv
// Shared definitions for the packet SRAM responder: bus widths, FSM state
// codes, the packet length limit and byte-lane helpers.
package pkt_sram_responder_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    RSP_FILL  = 2'd0,
    RSP_FLUSH = 2'd1,
    RSP_HOLD  = 2'd2
  } rsp_state_e;

  // Largest packet the buffer can store, in bytes.
  function automatic int pkt_len_max(input int depth_words);
    return 4 * depth_words;
  endfunction

  // Big-endian lane select: byte offset 0 lands in [31:24].
  function automatic logic [3:0] lane_onehot(input logic [1:0] off);
    return 4'b1000 >> off;
  endfunction

  // Expand a 4-bit lane mask to a 32-bit bit mask.
  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/pkt_sram_responder_if.sv
// SRAM bus plus ingress byte stream of the packet responder. The master
// modport is the initiator/stream source side, slave is the responder.
interface pkt_sram_responder_if;

  logic        sram_ce_i;
  logic        sram_we_i;
  logic [31:0] sram_addr_i;
  logic [3:0]  sram_sel_i;
  logic [31:0] sram_data_i;
  logic [31:0] sram_data_o;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_data_i;
  logic        in_last_i;

  modport master (
    output sram_ce_i, sram_we_i, sram_addr_i, sram_sel_i, sram_data_i,
    input  sram_data_o,
    output in_valid_i, in_data_i, in_last_i,
    input  in_ready_o
  );

  modport slave (
    input  sram_ce_i, sram_we_i, sram_addr_i, sram_sel_i, sram_data_i,
    output sram_data_o,
    input  in_valid_i, in_data_i, in_last_i,
    output in_ready_o
  );

endinterface

// File: rtl/pkt_sram_responder_be_word_ram.sv
// be_word_ram: DEPTH_WORDS x 32 storage with per-byte write enables and a
// registered read. Write and read addresses are separate because a
// pending ingress commit may share a cycle with a bus read.
module pkt_sram_responder_be_word_ram #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
  end

  // registered read, holds its value between reads
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_sram_responder.sv
// Packet buffer on the memory side of the 32-bit SRAM bus. Ingress bytes
// are packed big-endian into words and committed around bus writes; the
// finished packet is held until the consumer releases it.
// Build option: RESP_CKSUM_EN adds the ones'-complement checksum on
// pkt_cksum_o; without it the output is tied to zero.
//
// state     | meaning
// RSP_FILL  | accepting ingress bytes
// RSP_FLUSH | last byte taken, waiting for final commit (and checksum fold)
// RSP_HOLD  | packet stored and presented, waiting for pkt_release_i
module pkt_sram_responder
  import pkt_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic                clk,
  input  logic                rst,
  pkt_sram_responder_if.slave bus,
  output logic                pkt_ready_o,
  output logic [DATA_BUS-1:0] pkt_len_o,
  output logic                pkt_err_o,
  input  logic                pkt_release_i,
  output logic [15:0]         pkt_cksum_o
);

  localparam int CW = AW + 3;
  localparam logic [CW-1:0] LEN_MAX = CW'(pkt_len_max(DEPTH_WORDS));

  rsp_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   word_q, word_d;
  logic [3:0]    mask_q, mask_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [3:0]    pend_mask_q, pend_mask_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          ready_q, ready_d;
  logic [31:0]   len_q, len_d;
  logic          err_q, err_d;

  logic          bus_wr, bus_rd;
  logic [AW-1:0] bus_word;
  logic          in_ready, accept, ovf, word_end;
  logic [3:0]    lane, mask_m;
  logic [31:0]   word_m;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          fold_done;
  logic          unused_addr;

  assign bus_wr   = bus.sram_ce_i & bus.sram_we_i;
  assign bus_rd   = bus.sram_ce_i & ~bus.sram_we_i;
  assign bus_word = bus.sram_addr_i[AW+1:2];
  assign unused_addr = ^{bus.sram_addr_i[ADDR_BUS-1:AW+2], bus.sram_addr_i[1:0]};

  assign in_ready       = (state_q == RSP_FILL) & ~pend_valid_q & ~rst;
  assign bus.in_ready_o = in_ready;
  assign accept         = bus.in_valid_i & in_ready;
  assign ovf            = (cnt_q == LEN_MAX);
  assign word_end       = (cnt_q[1:0] == 2'd3) | bus.in_last_i;
  assign lane           = lane_onehot(cnt_q[1:0]);
  assign word_m         = word_q | ({4{bus.in_data_i}} & lane_bits(lane));
  assign mask_m         = mask_q | lane;

  // write source mux: bus write wins, pending ingress word takes idle cycles
  always_comb begin
    ram_we    = 4'b0000;
    ram_waddr = pend_addr_q;
    ram_wdata = pend_data_q;
    if (bus_wr) begin
      ram_we    = bus.sram_sel_i;
      ram_waddr = bus_word;
      ram_wdata = bus.sram_data_i;
    end else if (pend_valid_q) begin
      ram_we = pend_mask_q;
    end
  end

  pkt_sram_responder_be_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (bus_rd),
    .raddr_i(bus_word),
    .rdata_o(bus.sram_data_o)
  );

  // next state plus packing, pending commit and packet presentation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    mask_d       = mask_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    pend_addr_d  = pend_addr_q;
    ready_d      = ready_q;
    len_d        = len_q;
    err_d        = err_q;

    if (pend_valid_q && !bus_wr) pend_valid_d = 1'b0;

    case (state_q)
      RSP_FILL: begin
        if (accept) begin
          if (ovf) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (word_end) begin
              pend_valid_d = 1'b1;
              pend_data_d  = word_m;
              pend_mask_d  = mask_m;
              pend_addr_d  = cnt_q[AW+1:2];
              word_d       = ZERO_WORD;
              mask_d       = 4'b0000;
            end else begin
              word_d = word_m;
              mask_d = mask_m;
            end
          end
          if (bus.in_last_i) state_d = RSP_FLUSH;
        end
      end
      RSP_FLUSH: begin
        if (!pend_valid_q && fold_done) begin
          len_d   = 32'(cnt_q);
          ready_d = 1'b1;
          state_d = RSP_HOLD;
        end
      end
      RSP_HOLD: begin
        if (pkt_release_i) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = RSP_FILL;
        end
      end
      default: state_d = RSP_FILL;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RSP_FILL;
      cnt_q        <= '0;
      word_q       <= ZERO_WORD;
      mask_q       <= 4'b0000;
      pend_valid_q <= 1'b0;
      pend_data_q  <= ZERO_WORD;
      pend_mask_q  <= 4'b0000;
      pend_addr_q  <= '0;
      ready_q      <= 1'b0;
      len_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      pend_addr_q  <= pend_addr_d;
      ready_q      <= ready_d;
      len_q        <= len_d;
      err_q        <= err_d;
    end
  end

  assign pkt_ready_o = ready_q;
  assign pkt_len_o   = len_q;
  assign pkt_err_o   = err_q;

`ifdef RESP_CKSUM_EN
  logic        push;
  logic [31:0] sum_q, sum_d;
  logic        fold_q, fold_d;
  logic [15:0] cksum_q, cksum_d;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // unfilled lanes of a partial word are zero, which pads an odd byte
  assign push  = (state_q == RSP_FILL) & accept & ~ovf & word_end;
  assign fold1 = {1'b0, sum_q[31:16]} + {1'b0, sum_q[15:0]};
  assign fold2 = sum_q[15:0] + {15'h0000, sum_q[16]};
  assign fold_done = fold_q;

  // accumulate halfwords on push; first fold in FLUSH, second fold and
  // invert land together with pkt_ready_o
  always_comb begin
    sum_d   = sum_q;
    fold_d  = fold_q;
    cksum_d = cksum_q;
    if (push) sum_d = sum_q + {16'h0000, word_m[31:16]} + {16'h0000, word_m[15:0]};
    if (state_q == RSP_FLUSH) begin
      if (!fold_q) begin
        sum_d  = {15'h0000, fold1};
        fold_d = 1'b1;
      end else if (!pend_valid_q) begin
        cksum_d = ~fold2;
      end
    end
    if (state_q == RSP_HOLD && pkt_release_i) begin
      sum_d   = '0;
      fold_d  = 1'b0;
      cksum_d = '0;
    end
  end

  // checksum registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      fold_q  <= 1'b0;
      cksum_q <= '0;
    end else begin
      sum_q   <= sum_d;
      fold_q  <= fold_d;
      cksum_q <= cksum_d;
    end
  end

  assign pkt_cksum_o = cksum_q;
`else
  assign fold_done   = 1'b1;
  assign pkt_cksum_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pkt_sram_responder.sv
// Randomized bench for pkt_sram_responder with a byte-level memory model.
module tb_pkt_sram_responder;

  localparam int DW   = 8;
  localparam int AWT  = 3;
  localparam int MAXB = 4 * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_ready, pkt_err, pkt_release;
  logic [31:0] pkt_len;
  logic [15:0] pkt_cksum;

  pkt_sram_responder_if ifc ();

  pkt_sram_responder #(.DEPTH_WORDS(DW), .AW(AWT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc),
    .pkt_ready_o  (pkt_ready),
    .pkt_len_o    (pkt_len),
    .pkt_err_o    (pkt_err),
    .pkt_release_i(pkt_release),
    .pkt_cksum_o  (pkt_cksum)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_m [DW];
  logic [7:0]  pkt_b [64];
  logic [15:0] last_ck;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.sram_ce_i   = 1'b0;
    ifc.sram_we_i   = 1'b0;
    ifc.sram_addr_i = '0;
    ifc.sram_sel_i  = '0;
    ifc.sram_data_i = '0;
    ifc.in_valid_i  = 1'b0;
    ifc.in_data_i   = '0;
    ifc.in_last_i   = 1'b0;
  endtask

  function automatic logic [31:0] alias_addr(input int w);
    return ($urandom & ~32'h0000001C) | 32'(w << 2);
  endfunction

  function automatic void m_write(input int w, input logic [3:0] sel, input logic [31:0] d);
    for (int l = 0; l < 4; l++) if (sel[l]) mem_m[w][8*l +: 8] = d[8*l +: 8];
  endfunction

  function automatic void m_apply_pkt(input int stored);
    for (int n = 0; n < stored; n++) mem_m[n / 4][8*(3 - (n % 4)) +: 8] = pkt_b[n];
  endfunction

  function automatic logic [15:0] cksum_model(input int len);
`ifdef RESP_CKSUM_EN
    int unsigned s = 0;
    for (int n = 0; n < len; n += 2)
      s += {16'h0000, pkt_b[n], (n + 1 < len) ? pkt_b[n+1] : 8'h00};
    while ((s >> 16) != 0) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~s[15:0];
`else
    return (len < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic bus_write(input int w, input logic [3:0] sel, input logic [31:0] d);
    ifc.sram_ce_i = 1'b1; ifc.sram_we_i = 1'b1;
    ifc.sram_addr_i = alias_addr(w); ifc.sram_sel_i = sel; ifc.sram_data_i = d;
    tick();
    ifc.sram_ce_i = 1'b0; ifc.sram_we_i = 1'b0;
    m_write(w, sel, d);
  endtask

  task automatic read_exp(input string tag, input int w, input logic [31:0] exp);
    ifc.sram_ce_i = 1'b1; ifc.sram_we_i = 1'b0; ifc.sram_addr_i = alias_addr(w);
    tick();
    ifc.sram_ce_i = 1'b0;
    chk(tag, ifc.sram_data_o, exp);
  endtask

  // random-valid ingress with optional bus traffic on words 6/7
  task automatic send_pkt(input int len, input bit traffic);
    int idx = 0;
    int guard = 0;
    bit done = 1'b0;
    bit early = 1'b0;
    while (!done && guard < 4000) begin
      bit acc; bit rd; int tw; logic [31:0] rexp;
      ifc.in_valid_i = ($urandom_range(0, 3) != 0);
      ifc.in_data_i  = pkt_b[idx];
      ifc.in_last_i  = (idx == len - 1);
      pkt_release    = ($urandom_range(0, 7) == 0);
      ifc.sram_ce_i  = 1'b0; ifc.sram_we_i = 1'b0;
      rd = 1'b0; rexp = '0;
      if (traffic) begin
        tw = 6 + $urandom_range(0, 1);
        ifc.sram_addr_i = alias_addr(tw);
        case ($urandom_range(0, 3))
          1: begin
            ifc.sram_ce_i = 1'b1; ifc.sram_we_i = 1'b1;
            ifc.sram_sel_i = 4'($urandom); ifc.sram_data_i = $urandom;
            m_write(tw, ifc.sram_sel_i, ifc.sram_data_i);
          end
          2: begin
            ifc.sram_ce_i = 1'b1; rexp = mem_m[tw]; rd = 1'b1;
          end
          default: ;
        endcase
      end
      acc = ifc.in_valid_i & ifc.in_ready_o;
      tick();
      if (rd) chk("trf_rd", ifc.sram_data_o, rexp);
      if (pkt_ready) early = 1'b1;
      if (acc) begin
        done = ifc.in_last_i;
        idx++;
      end
      guard++;
    end
    idle();
    pkt_release = 1'b0;
    chk("ingress_to", 32'(done), 32'd1);
    chk("rdy_early", 32'(early), 32'd0);
  endtask

  // continuous-valid ingress of n bytes; returns right after the last accept
  task automatic feed(input int n, input bit with_last);
    int idx = 0;
    int g = 0;
    while (idx < n && g < 200) begin
      bit acc;
      ifc.in_valid_i = 1'b1;
      ifc.in_data_i  = pkt_b[idx];
      ifc.in_last_i  = with_last && (idx == n - 1);
      acc = ifc.in_ready_o;
      tick();
      if (acc) idx++;
      g++;
    end
    ifc.in_valid_i = 1'b0; ifc.in_last_i = 1'b0;
    chk("feed_to", 32'(idx), 32'(n));
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!pkt_ready && g < 20) begin
      tick();
      g++;
    end
    chk("ready_to", 32'(pkt_ready), 32'd1);
  endtask

  task automatic release_pkt();
    pkt_release = 1'b1;
    tick();
    pkt_release = 1'b0;
    chk("rel_ready", 32'(pkt_ready), 32'd0);
    chk("rel_err", 32'(pkt_err), 32'd0);
    chk("rel_inrdy", 32'(ifc.in_ready_o), 32'd1);
  endtask

  // check presentation and stored words of a packet, then release it
  task automatic finish_pkt(input int len);
    int stored = (len > MAXB) ? MAXB : len;
    wait_ready();
    last_ck = pkt_cksum;
    chk("len", pkt_len, 32'(stored));
    chk("err", 32'(pkt_err), 32'(len > MAXB));
    chk("cksum", 32'(pkt_cksum), 32'(cksum_model(stored)));
    chk("hold_inrdy", 32'(ifc.in_ready_o), 32'd0);
    m_apply_pkt(stored);
    for (int w = 0; w < (stored + 3) / 4; w++) read_exp("pkt_word", w, mem_m[w]);
    release_pkt();
  endtask

  task automatic run_pkt(input int len, input bit traffic);
    send_pkt(len, traffic);
    finish_pkt(len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    pkt_release = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(pkt_ready), 32'd0);
    chk("rst_len", pkt_len, 32'd0);
    chk("rst_err", 32'(pkt_err), 32'd0);
    chk("rst_cksum", 32'(pkt_cksum), 32'd0);
    chk("rst_rdata", ifc.sram_data_o, 32'd0);
    chk("rst_inrdy", 32'(ifc.in_ready_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("fill_inrdy", 32'(ifc.in_ready_o), 32'd1);

    for (int w = 0; w < DW; w++) bus_write(w, 4'hF, $urandom);

    // four-byte packet
    pkt_b[0] = 8'h45; pkt_b[1] = 8'h00; pkt_b[2] = 8'h00; pkt_b[3] = 8'h1C;
    run_pkt(4, 1'b0);
    read_exp("ip4_word0", 0, 32'h4500001C);

    // partial last word leaves unfilled lanes untouched
    bus_write(1, 4'hF, 32'hAAAAAAAA);
    for (int i = 0; i < 6; i++) pkt_b[i] = 8'(i + 1);
    run_pkt(6, 1'b0);
    read_exp("part_word1", 1, 32'h0506AAAA);

    // bus write colliding with the pending final word
    bus_write(1, 4'hF, 32'h11111111);
    feed(6, 1'b1);
    chk("cfl_inrdy", 32'(ifc.in_ready_o), 32'd0);
    ifc.sram_ce_i = 1'b1; ifc.sram_we_i = 1'b1; ifc.sram_addr_i = 32'd4;
    ifc.sram_sel_i = 4'hF; ifc.sram_data_i = 32'hDEADBEEF;
    tick();
    idle();
    m_write(1, 4'hF, 32'hDEADBEEF);
    finish_pkt(6);
    read_exp("cfl_word1", 1, 32'h0506BEEF);

    // reset mid-packet discards the partial packet
    bus_write(0, 4'hF, 32'h77777777);
    pkt_b[0] = 8'hA1; pkt_b[1] = 8'hA2; pkt_b[2] = 8'hA3;
    feed(3, 1'b0);
    rst = 1'b1;
    tick();
    chk("rstmid_inrdy", 32'(ifc.in_ready_o), 32'd0);
    chk("rstmid_ready", 32'(pkt_ready), 32'd0);
    rst = 1'b0;
    tick();
    read_exp("rstmid_word0", 0, 32'h77777777);
    pkt_b[0] = 8'hB1; pkt_b[1] = 8'hB2; pkt_b[2] = 8'hB3; pkt_b[3] = 8'hB4;
    run_pkt(4, 1'b0);
    read_exp("rstmid_new0", 0, 32'hB1B2B3B4);

`ifdef RESP_CKSUM_EN
    begin
      logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                              8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01,
                              8'hC0, 8'hA8, 8'h00, 8'hC7};
      for (int i = 0; i < 20; i++) pkt_b[i] = hdr[i];
      run_pkt(20, 1'b0);
      chk("ipv4_cksum", 32'(last_ck), 32'h0000B861);
    end
`endif

    // capacity boundary: exactly full, then one byte over
    for (int i = 0; i < 40; i++) pkt_b[i] = 8'($urandom);
    run_pkt(MAXB, 1'b0);
    for (int i = 0; i < 40; i++) pkt_b[i] = 8'($urandom);
    run_pkt(MAXB + 1, 1'b0);
    pkt_b[0] = 8'h5A;
    run_pkt(1, 1'b0);
    read_exp("after_ovf0", 0, mem_m[0]);

    for (int p = 0; p < 30; p++) begin
      int len;
      bit trf;
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(MAXB + 1, MAXB + 8);
        trf = 1'b0;
      end else begin
        len = $urandom_range(1, 24);
        trf = 1'b1;
      end
      for (int i = 0; i < len; i++) pkt_b[i] = 8'($urandom);
      run_pkt(len, trf);
    end

    for (int w = 0; w < DW; w++) read_exp("final_mem", w, mem_m[w]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
